// File: rtl/mci_responder_params.sv
// Responder FSM state type and address/counter geometry derived from the line width.
package mci_responder_params;

  import memory_controller_interface::*;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  localparam int LINE_OFFSET_BITS = $clog2(MCI_DATA_LENGTH / 8);
  localparam int CNT_W            = 8;

endpackage

// File: rtl/memory_controller_interface.sv
// Request/response types shared by the data cache and the memory responder.
package memory_controller_interface;

  localparam int MCI_DATA_LENGTH = 128;

  typedef struct packed {
    logic [31:0]                addr;
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       rw;
    logic                       valid;
  } mci_request_t;

  typedef struct packed {
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       ready;
  } mci_response_t;

endpackage

// File: rtl/mci_line_ram.sv
// Line-wide backing store: asynchronous read, synchronous write on i_we.
module mci_line_ram #(
  parameter int DEPTH_LINES = 1024,
  parameter int WIDTH       = 128,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mci_mem_responder.sv
// MCI responder: latches one line request and answers it LATENCY cycles later from a line RAM.
// Define MCI_RESP_PROTO_CHECK_EN to add the sticky proto_err output.
module mci_mem_responder
  import memory_controller_interface::*;
  import mci_responder_params::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  mci_request_t  mem_req,
  output mci_response_t mem_res
`ifdef MCI_RESP_PROTO_CHECK_EN
  ,
  output logic          proto_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_count;
  logic [IDX_W-1:0]           r_idx;
  logic [MCI_DATA_LENGTH-1:0] r_wdata;
  logic                       r_rw;
  logic                       r_ready;

  logic [IDX_W-1:0]           w_idx;
  logic                       w_accepting;
  logic                       w_bad_rw;
  logic                       w_accept;
  logic                       w_we;
  logic [MCI_DATA_LENGTH-1:0] w_rdata;
  logic                       w_unused_addr;

  // Offset and upper address bits are intentionally dropped; lines alias.
  assign w_idx         = mem_req.addr[LINE_OFFSET_BITS +: IDX_W];
  assign w_unused_addr = ^mem_req.addr;

`ifdef MCI_RESP_PROTO_CHECK_EN
`ifndef SYNTHESIS
  assign w_bad_rw = mem_req.valid && $isunknown(mem_req.rw);
`else
  assign w_bad_rw = 1'b0;
`endif
`else
  assign w_bad_rw = 1'b0;
`endif

  assign w_accepting = (r_state == IDLE) || (r_state == RESPOND);
  assign w_accept    = w_accepting && mem_req.valid && !w_bad_rw;
  // Reset wins over a write landing on the same edge.
  assign w_we        = (r_state == RESPOND) && r_rw && !rst;

  mci_line_ram #(
    .DEPTH_LINES (DEPTH_LINES),
    .WIDTH       (MCI_DATA_LENGTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESPOND: begin
          r_ready <= 1'b0;
          if (w_accept) begin
            r_idx   <= w_idx;
            r_wdata <= mem_req.data;
            r_rw    <= mem_req.rw;
            r_count <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state <= RESPOND;
              r_ready <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= RESPOND;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_res       = '0;
    mem_res.ready = r_ready;
    if (r_ready && !r_rw) begin
      mem_res.data = w_rdata;
    end
  end

`ifdef MCI_RESP_PROTO_CHECK_EN
  logic r_proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (mem_req.valid && ((r_state == BUSY) || w_bad_rw)) begin
      r_proto_err <= 1'b1;
`ifndef SYNTHESIS
      $error("mci_mem_responder: request dropped (valid while busy or unknown rw)");
`endif
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_mci_mem_responder.sv
// Randomized self-checking bench: LATENCY=4 and LATENCY=1 responders against an associative-array memory model.
module tb_mci_mem_responder;
  import memory_controller_interface::*;

  logic          clk;
  logic          rst;
  mci_request_t  req4, req1;
  mci_response_t res4, res1;
`ifdef MCI_RESP_PROTO_CHECK_EN
  logic          perr4, perr1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [127:0] ref4 [int];
  logic [127:0] ref1 [int];

  localparam logic [127:0] PATTERN = 128'h0123456789ABCDEF0123456789ABCDEF;

  mci_mem_responder #(.DEPTH_LINES(1024), .LATENCY(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .mem_req (req4),
    .mem_res (res4)
`ifdef MCI_RESP_PROTO_CHECK_EN
    ,
    .proto_err (perr4)
`endif
  );

  mci_mem_responder #(.DEPTH_LINES(16), .LATENCY(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .mem_req (req1),
    .mem_res (res1)
`ifdef MCI_RESP_PROTO_CHECK_EN
    ,
    .proto_err (perr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx4(logic [31:0] a);
    return int'((a >> 4) & 32'h3FF);
  endfunction

  function automatic logic [31:0] addr_for4(int line);
    return ($urandom() & 32'hFFFF_C00F) | (32'(line) << 4);
  endfunction

  function automatic logic [31:0] addr_for1(int line);
    return ($urandom() & 32'hFFFF_FF0F) | (32'(line) << 4);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a request for one cycle (call away from the edge); the address is scrambled afterwards.
  task automatic drive4(input logic rw, input logic [31:0] a, input logic [127:0] d);
    req4.addr  = a;
    req4.data  = d;
    req4.rw    = rw;
    req4.valid = 1'b1;
    @(posedge clk);
    #1;
    req4.valid = 1'b0;
    req4.addr  = $urandom();
    req4.data  = '0;
  endtask

  // Cycles until ready, counted from the first cycle after acceptance; 0 means it never came.
  task automatic wait4(output int lat, output logic [127:0] d, output bit dirty);
    lat   = 0;
    d     = '0;
    dirty = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res4.ready === 1'b1) begin
        lat = i;
        d   = res4.data;
        break;
      end
      if (res4.data !== '0) dirty = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req4 = '0;
    req1 = '0;
    repeat (3) @(negedge clk);
    checks++; if (res4.ready !== 1'b0) begin failures++; $display("FAIL reset_ready4 got=%b exp=0", res4.ready); end
    checks++; if (res4.data !== '0) begin failures++; $display("FAIL reset_data4 got=%h exp=0", res4.data); end
    checks++; if (res1.ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", res1.ready); end
    checks++; if (res1.data !== '0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", res1.data); end
`ifdef MCI_RESP_PROTO_CHECK_EN
    checks++; if (perr4 !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", perr4); end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (res4.ready !== 1'b0 || res1.ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b/%b exp=0/0", res4.ready, res1.ready); end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] d; bit dirty;
    @(negedge clk);
    drive4(1'b1, 32'h0000_0040, PATTERN);
    ref4[idx4(32'h40)] = PATTERN;
    wait4(lat, d, dirty);
    $display("write 0x40 lat=%0d data=%h", lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wr40_lat got=%0d exp=4", lat); end
    checks++; if (d !== '0) begin failures++; $display("FAIL wr40_data got=%h exp=0", d); end
    checks++; if (dirty) begin failures++; $display("FAIL wr40_idle_data got=nonzero exp=0"); end
    @(negedge clk);
    drive4(1'b0, 32'h0000_0040, '0);
    wait4(lat, d, dirty);
    $display("read 0x40 lat=%0d data=%h", lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL rd40_lat got=%0d exp=4", lat); end
    checks++; if (d !== PATTERN) begin failures++; $display("FAIL rd40_data got=%h exp=%h", d, PATTERN); end
    checks++; if (dirty) begin failures++; $display("FAIL rd40_idle_data got=nonzero exp=0"); end
    @(negedge clk);
    drive4(1'b0, 32'h0000_0048, '0);
    wait4(lat, d, dirty);
    $display("read 0x48 lat=%0d data=%h", lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL rd48_lat got=%0d exp=4", lat); end
    checks++; if (d !== PATTERN) begin failures++; $display("FAIL rd48_data got=%h exp=%h", d, PATTERN); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] d; bit dirty; logic [127:0] a_val;
    a_val = rand128();
    @(negedge clk);
    drive4(1'b1, 32'h0000_0100, a_val);
    ref4[idx4(32'h100)] = a_val;
    wait4(lat, d, dirty);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_wr_lat got=%0d exp=4", lat); end
    // Read issued inside the write's ready cycle.
    drive4(1'b0, 32'h0000_0100, '0);
    wait4(lat, d, dirty);
    $display("b2b read 0x100 lat=%0d data=%h", lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_rd_lat got=%0d exp=4", lat); end
    checks++; if (d !== a_val) begin failures++; $display("FAIL b2b_rd_data got=%h exp=%h", d, a_val); end
  endtask

  task automatic test_random_stream();
    int lat; logic [127:0] d; bit dirty;
    int gap; int line; logic rw; logic [31:0] a; logic [127:0] wd, exp;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      line = $urandom_range(0, 7);
      rw   = 1'($urandom_range(0, 1));
      if (!ref4.exists(line)) rw = 1'b1;
      a    = addr_for4(line);
      wd   = rand128();
      exp  = rw ? '0 : ref4[line];
      if (rw) ref4[line] = wd;
      drive4(rw, a, wd);
      wait4(lat, d, dirty);
      $display("rand4 #%0d rw=%0d addr=%h gap=%0d lat=%0d data=%h", i, rw, a, gap, lat, d);
      checks++; if (lat !== 4) begin failures++; $display("FAIL rand4_lat got=%0d exp=4", lat); end
      checks++; if (d !== exp) begin failures++; $display("FAIL rand4_data got=%h exp=%h", d, exp); end
      checks++; if (dirty) begin failures++; $display("FAIL rand4_idle_data got=nonzero exp=0"); end
    end
  endtask

  task automatic test_latency1();
    logic [127:0] exp_q[$];
    int len; int line; logic rw; logic [31:0] a; logic [127:0] wd;
    for (int b = 0; b < 15; b++) begin
      @(negedge clk);
      len = (b == 0) ? 3 : $urandom_range(1, 4);
      exp_q.delete();
      for (int k = 0; k <= len; k++) begin
        if (k > 0) begin
          $display("lat1 burst=%0d resp=%0d ready=%b data=%h", b, k - 1, res1.ready, res1.data);
          checks++; if (res1.ready !== 1'b1) begin failures++; $display("FAIL lat1_ready got=%b exp=1", res1.ready); end
          checks++; if (res1.data !== exp_q[k-1]) begin failures++; $display("FAIL lat1_data got=%h exp=%h", res1.data, exp_q[k-1]); end
        end
        if (k < len) begin
          line = $urandom_range(0, 5);
          rw   = 1'($urandom_range(0, 1));
          if (!ref1.exists(line)) rw = 1'b1;
          a  = addr_for1(line);
          wd = rand128();
          exp_q.push_back(rw ? 128'h0 : ref1[line]);
          if (rw) ref1[line] = wd;
          req1.addr = a; req1.data = wd; req1.rw = rw; req1.valid = 1'b1;
        end else begin
          req1.valid = 1'b0;
        end
        @(negedge clk);
      end
      checks++; if (res1.ready !== 1'b0 || res1.data !== '0) begin failures++; $display("FAIL lat1_after got=%b/%h exp=0/0", res1.ready, res1.data); end
    end
  endtask

  task automatic test_protocol();
    int lat; logic [127:0] d; bit dirty; int extra;
    logic [127:0] q_val, s_val, p_val, r_val;
    q_val = rand128(); s_val = rand128(); p_val = rand128(); r_val = rand128();
    @(negedge clk);
    drive4(1'b1, 32'h0000_0200, q_val); wait4(lat, d, dirty);
    @(negedge clk);
    drive4(1'b1, 32'h0000_0300, s_val); wait4(lat, d, dirty);
    ref4[idx4(32'h300)] = s_val;
    @(negedge clk);
    drive4(1'b1, 32'h0000_0200, p_val);
    ref4[idx4(32'h200)] = p_val;
    // Stray request while busy; one cycle of the original latency already elapsed.
    drive4(1'b1, 32'h0000_0300, r_val);
    wait4(lat, d, dirty);
    $display("proto original lat_after_stray=%0d", lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL proto_orig_lat got=%0d exp=3", lat); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (res4.ready === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL proto_extra_ready got=%0d exp=0", extra); end
`ifdef MCI_RESP_PROTO_CHECK_EN
    checks++; if (perr4 !== 1'b1) begin failures++; $display("FAIL proto_err_set got=%b exp=1", perr4); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (perr4 !== 1'b0) begin failures++; $display("FAIL proto_err_clr got=%b exp=0", perr4); end
`endif
    @(negedge clk);
    drive4(1'b0, 32'h0000_0300, '0); wait4(lat, d, dirty);
    $display("proto read 0x300 data=%h", d);
    checks++; if (d !== s_val) begin failures++; $display("FAIL proto_dropped_wr got=%h exp=%h", d, s_val); end
    @(negedge clk);
    drive4(1'b0, 32'h0000_0200, '0); wait4(lat, d, dirty);
    checks++; if (d !== p_val) begin failures++; $display("FAIL proto_orig_wr got=%h exp=%h", d, p_val); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] d; bit dirty; int extra;
    logic [127:0] v_val, t_val;
    v_val = rand128(); t_val = rand128();
    @(negedge clk);
    drive4(1'b1, 32'h0000_0500, v_val); wait4(lat, d, dirty);
    ref4[idx4(32'h500)] = v_val;
    @(negedge clk);
    drive4(1'b1, 32'h0000_0500, t_val);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (res4.ready !== 1'b0 || res4.data !== '0) begin failures++; $display("FAIL rstmid_outputs got=%b/%h exp=0/0", res4.ready, res4.data); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (res4.ready === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL rstmid_ready got=%0d exp=0", extra); end
    @(negedge clk);
    drive4(1'b0, 32'h0000_0500, '0); wait4(lat, d, dirty);
    $display("rstmid read 0x500 lat=%0d data=%h", lat, d);
    checks++; if (lat !== 4) begin failures++; $display("FAIL rstmid_rd_lat got=%0d exp=4", lat); end
    checks++; if (d !== v_val) begin failures++; $display("FAIL rstmid_line got=%h exp=%h", d, v_val); end
  endtask

  initial begin
    rst  = 1'b1;
    req4 = '0;
    req1 = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random_stream();
    test_latency1();
    test_protocol();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
